// File: rtl/mc_cpu_pkg.sv
// Shared types and instruction-field positions for the multi-cycle core.
// The 16-bit instruction format is fixed regardless of the datapath width.
package mc_cpu_pkg;

    localparam int INSTR_W   = 16;
    localparam int REG_IDX_W = 2;

    localparam int OP_HI   = 15;
    localparam int OP_LO   = 12;
    localparam int RI_HI   = 11;
    localparam int RI_LO   = 10;
    localparam int RJ_HI   = 9;
    localparam int RJ_LO   = 8;
    localparam int IMM_HI  = 7;
    localparam int IMM_LO  = 0;
    localparam int ADDR_HI = 9;
    localparam int ADDR_LO = 0;
    localparam int FN_HI   = 3;
    localparam int FN_LO   = 0;

    typedef enum logic [3:0] {
        OP_LOAD  = 4'h0,
        OP_STORE = 4'h1,
        OP_JUMP  = 4'h2,
        OP_BZ    = 4'h3,
        OP_HALT  = 4'h7,
        OP_RTYPE = 4'h8,
        OP_ADDI  = 4'hC,
        OP_SUBI  = 4'hD,
        OP_ANDI  = 4'hE,
        OP_ORI   = 4'hF
    } opcode_t;

    typedef enum logic [3:0] {
        FN_ADD = 4'h0,
        FN_SUB = 4'h1,
        FN_AND = 4'h2,
        FN_OR  = 4'h3,
        FN_NOT = 4'h4,
        FN_MOV = 4'h5,
        FN_NOP = 4'h6,
        FN_WND = 4'h7
    } func_t;

    typedef enum logic [1:0] {
        S_FETCH,
        S_EXEC,
        S_MEM,
        S_HALT
    } state_t;

endpackage

// File: rtl/windowed_reg_file.sv
// Windowed register file: 2*NUM_WND physical registers, four visible per window,
// adjacent windows overlapping by two registers.
module windowed_reg_file
    import mc_cpu_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int NUM_WND = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [$clog2(NUM_WND)-1:0] window,
    input  logic [REG_IDX_W-1:0]       ra_idx,
    input  logic [REG_IDX_W-1:0]       rb_idx,
    output logic [DATA_W-1:0]          ra_data,
    output logic [DATA_W-1:0]          rb_data,
    input  logic                       we,
    input  logic [REG_IDX_W-1:0]       wr_idx,
    input  logic [DATA_W-1:0]          wr_data
);

    localparam int NUM_PHYS = 2 * NUM_WND;
    localparam int PHYS_W   = $clog2(NUM_PHYS);

    logic [DATA_W-1:0] regs [NUM_PHYS];

    // Logical Rk of window w lives at physical (2w + k) mod 2*NUM_WND.
    function automatic logic [PHYS_W-1:0] to_phys(
        input logic [$clog2(NUM_WND)-1:0] w,
        input logic [REG_IDX_W-1:0]       k
    );
        int p;
        p = (2 * int'(w) + int'(k)) % NUM_PHYS;
        return PHYS_W'(p);
    endfunction

    assign ra_data = regs[to_phys(window, ra_idx)];
    assign rb_data = regs[to_phys(window, rb_idx)];

    // NOTE: this array is deliberately reset (the core must start from all-zero
    // registers), so it maps to flops, not a RAM macro that has no reset.
    // NOTE: sequential state is always assigned with <= so every flop samples
    // pre-edge values; = here would create order-dependent simulation races.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_PHYS; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[to_phys(window, wr_idx)] <= wr_data;
        end
    end

endmodule

// File: rtl/mc_cpu_core.sv
// Multi-cycle 16-bit-ISA core: FETCH/EXEC/MEM sequencing over a single shared
// req/ready memory port, with register windows, HALT and illegal-opcode flag.
module mc_cpu_core
    import mc_cpu_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 10,
    parameter int NUM_WND  = 4,
    parameter int RESET_PC = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic                       mem_req,
    output logic                       mem_we,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic [DATA_W-1:0]          mem_wdata,
    input  logic [DATA_W-1:0]          mem_rdata,
    input  logic                       mem_ready,
    output logic [ADDR_W-1:0]          pc,
    output logic [$clog2(NUM_WND)-1:0] window,
    output logic                       retire,
    output logic                       halted,
    output logic                       illegal
);

    localparam int WND_W = $clog2(NUM_WND);

    state_t               state, state_next;
    logic [ADDR_W-1:0]    pc_next;
    logic [INSTR_W-1:0]   ir, ir_next;
    logic [WND_W-1:0]     wnd_next;
    logic                 illegal_next;

    logic [3:0]           op;
    logic [3:0]           fn;
    logic [REG_IDX_W-1:0] ri, rj;
    logic [7:0]           imm8;
    logic [ADDR_W-1:0]    addr_ext;
    logic [DATA_W-1:0]    imm_ext;

    logic [DATA_W-1:0]    ri_data, rj_data;
    logic [DATA_W-1:0]    alu_res, wr_data;
    logic                 alu_we, wr_en;

    assign op       = ir[OP_HI:OP_LO];
    assign fn       = ir[FN_HI:FN_LO];
    assign ri       = ir[RI_HI:RI_LO];
    assign rj       = ir[RJ_HI:RJ_LO];
    assign imm8     = ir[IMM_HI:IMM_LO];
    assign addr_ext = ADDR_W'(ir[ADDR_HI:ADDR_LO]);
    assign imm_ext  = DATA_W'(imm8);
    assign halted   = (state == S_HALT);

    windowed_reg_file #(
        .DATA_W  (DATA_W),
        .NUM_WND (NUM_WND)
    ) u_rf (
        .clk     (clk),
        .rst     (rst),
        .window  (window),
        .ra_idx  (ri),
        .rb_idx  (rj),
        .ra_data (ri_data),
        .rb_data (rj_data),
        .we      (wr_en),
        .wr_idx  (ri),
        .wr_data (wr_data)
    );

    // NOTE: every always_comb output gets a default before any branch; a path
    // that leaves one unassigned would infer a latch.
    always_comb begin
        alu_res = ri_data;
        alu_we  = 1'b0;
        case (op)
            OP_RTYPE: begin
                alu_we = 1'b1;
                case (fn)
                    FN_ADD:  alu_res = ri_data + rj_data;
                    FN_SUB:  alu_res = ri_data - rj_data;
                    FN_AND:  alu_res = ri_data & rj_data;
                    FN_OR:   alu_res = ri_data | rj_data;
                    FN_NOT:  alu_res = ~rj_data;
                    FN_MOV:  alu_res = rj_data;
                    default: alu_we  = 1'b0;
                endcase
            end
            OP_ADDI: begin alu_res = ri_data + imm_ext; alu_we = 1'b1; end
            OP_SUBI: begin alu_res = ri_data - imm_ext; alu_we = 1'b1; end
            OP_ANDI: begin alu_res = ri_data & imm_ext; alu_we = 1'b1; end
            OP_ORI:  begin alu_res = ri_data | imm_ext; alu_we = 1'b1; end
            default: ;
        endcase
    end

    always_comb begin
        state_next   = state;
        pc_next      = pc;
        ir_next      = ir;
        wnd_next     = window;
        illegal_next = illegal;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = pc;
        mem_wdata    = ri_data;
        retire       = 1'b0;
        wr_en        = 1'b0;
        wr_data      = alu_res;

        case (state)
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_next    = mem_rdata[INSTR_W-1:0];
                    pc_next    = pc + ADDR_W'(1);
                    state_next = S_EXEC;
                end
            end
            S_EXEC: begin
                retire     = 1'b1;
                state_next = S_FETCH;
                case (op)
                    OP_LOAD, OP_STORE: begin
                        retire     = 1'b0;
                        state_next = S_MEM;
                    end
                    OP_HALT: begin
                        retire     = 1'b0;
                        state_next = S_HALT;
                    end
                    OP_JUMP: pc_next = addr_ext;
                    // pc already points past the branch, so its page bits are reused.
                    OP_BZ: begin
                        if (ri_data == '0) begin
                            pc_next = {pc[ADDR_W-1:8], imm8};
                        end
                    end
                    OP_RTYPE: begin
                        wr_en = alu_we;
                        if (fn == FN_WND) begin
                            wnd_next = (window == WND_W'(NUM_WND - 1)) ? '0 : window + WND_W'(1);
                        end
                    end
                    OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI: wr_en = 1'b1;
                    default: illegal_next = 1'b1;
                endcase
            end
            S_MEM: begin
                mem_req  = 1'b1;
                mem_we   = (op == OP_STORE);
                mem_addr = addr_ext;
                if (mem_ready) begin
                    retire     = 1'b1;
                    wr_en      = (op == OP_LOAD);
                    wr_data    = mem_rdata;
                    state_next = S_FETCH;
                end
            end
            S_HALT: ;
            default: state_next = S_FETCH;
        endcase

        // A cycle under reset must not start a transfer or report a retirement.
        if (rst) begin
            mem_req = 1'b0;
            mem_we  = 1'b0;
            retire  = 1'b0;
            wr_en   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_FETCH;
            pc      <= ADDR_W'(RESET_PC);
            ir      <= '0;
            window  <= '0;
            illegal <= 1'b0;
        end else begin
            state   <= state_next;
            pc      <= pc_next;
            ir      <= ir_next;
            window  <= wnd_next;
            illegal <= illegal_next;
        end
    end

endmodule

// File: tb/tb_mc_cpu_core.sv
// Self-checking bench for mc_cpu_core: small programs in a behavioural memory,
// stores checked against a scoreboard of expected (address, data) pairs.
module tb_mc_cpu_core;

    localparam int DATA_W  = 16;
    localparam int ADDR_W  = 10;
    localparam int NUM_WND = 4;

    logic              clk;
    logic              rst;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;
    logic [ADDR_W-1:0] pc;
    logic [1:0]        window;
    logic              retire;
    logic              halted;
    logic              illegal;

    typedef struct packed {
        logic [9:0]  addr;
        logic [15:0] data;
    } st_t;

    logic [15:0] mem [1024];
    st_t         exp_q [$];
    st_t         mon_e;
    int          n_checks = 0;
    int          n_fail   = 0;
    int          retire_cnt = 0;
    int          n_st_seen  = 0;
    int          n_st_exp   = 0;
    int          cyc;

    mc_cpu_core #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .NUM_WND  (NUM_WND),
        .RESET_PC (0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .pc        (pc),
        .window    (window),
        .retire    (retire),
        .halted    (halted),
        .illegal   (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Garbage on the read bus while not ready exposes early captures.
    assign mem_rdata = mem_ready ? mem[mem_addr] : 16'hDEAD;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change at the falling edge; this monitor samples 2 time units later.
    always @(negedge clk) begin
        #2;
        if (!rst) begin
            if (retire) retire_cnt++;
            if (mem_req && mem_we && mem_ready) begin
                n_st_seen++;
                mem[mem_addr] = mem_wdata;
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    check("st_addr", 32'(mem_addr), 32'(mon_e.addr));
                    check("st_data", 32'(mem_wdata), 32'(mon_e.data));
                end
            end
        end
    end

    task automatic expect_store(input logic [9:0] a, input logic [15:0] d);
        exp_q.push_back('{addr: a, data: d});
        n_st_exp++;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        mem_ready = 1'b1;
        #1;
        check("rst_req", 32'(mem_req), 0);
        @(negedge clk);
        #1;
        check("rst_pc", 32'(pc), 0);
        check("rst_window", 32'(window), 0);
        check("rst_halted", 32'(halted), 0);
        check("rst_illegal", 32'(illegal), 0);
        check("rst_retire", 32'(retire), 0);
        for (int i = 0; i < 1024; i++) mem[i] = 16'h7000;
        exp_q.delete();
        n_st_exp = 0;
    endtask

    task automatic release_rst();
        retire_cnt = 0;
        n_st_seen  = 0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("fetch_req", 32'(mem_req), 1);
        check("fetch_addr", 32'(mem_addr), 0);
        check("fetch_we", 32'(mem_we), 0);
    endtask

    task automatic wait_halt(output int cycles);
        cycles = 0;
        while (!halted && cycles < 1000) begin
            @(negedge clk);
            #1;
            cycles++;
        end
        check("halt_reached", 32'(halted), 1);
    endtask

    task automatic end_run(input int n_ret, input int exp_pc);
        check("retires", 32'(retire_cnt), 32'(n_ret));
        check("pc_final", 32'(pc), 32'(exp_pc));
        check("st_count", 32'(n_st_seen), 32'(n_st_exp));
        check("halt_req", 32'(mem_req), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        mem_ready = 1'b1;

        // NOP stream: fetch at 0, pc=1 after fetch, retire every other cycle.
        do_reset();
        for (int i = 0; i < 32; i++) mem[i] = 16'h8006;
        release_rst();
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            #1;
            check("nop_retire", 32'(retire), 32'(i % 2));
            if (i == 1) check("pc_after_fetch", 32'(pc), 1);
        end
        wait_halt(cyc);
        check("nop_halt_cycles", 32'(cyc + 6), 66);
        end_run(32, 33);

        // ADDI/ADDI/STORE
        do_reset();
        mem[0] = 16'hC405;
        mem[1] = 16'hC403;
        mem[2] = 16'h1420;
        expect_store(10'h020, 16'h0008);
        release_rst();
        wait_halt(cyc);
        end_run(3, 4);

        // Window overlap and wrap-around
        do_reset();
        mem[0]  = 16'hC811;
        mem[1]  = 16'h8007;
        mem[2]  = 16'h1001;
        mem[3]  = 16'h8007;
        mem[4]  = 16'h8007;
        mem[5]  = 16'h8007;
        mem[6]  = 16'hC02A;
        mem[7]  = 16'h8007;
        mem[8]  = 16'h8007;
        mem[9]  = 16'h8007;
        mem[10] = 16'h1802;
        mem[11] = 16'h8007;
        expect_store(10'h001, 16'h0011);
        expect_store(10'h002, 16'h002A);
        release_rst();
        wait_halt(cyc);
        check("wnd_final", 32'(window), 0);
        end_run(12, 13);

        // Branch taken / not taken, JUMP to 0x3FF then pc wraps
        do_reset();
        mem[10'h000] = 16'h2105;
        mem[10'h105] = 16'h3C40;
        mem[10'h140] = 16'h1C30;
        mem[10'h141] = 16'hCC01;
        mem[10'h142] = 16'h2105;
        mem[10'h106] = 16'h1C31;
        mem[10'h107] = 16'h23FF;
        expect_store(10'h030, 16'h0000);
        expect_store(10'h031, 16'h0001);
        release_rst();
        wait_halt(cyc);
        end_run(8, 0);

        // LOAD with three wait states
        do_reset();
        mem[0]      = 16'h0450;
        mem[1]      = 16'h1451;
        mem[10'h050] = 16'hBEEF;
        expect_store(10'h051, 16'hBEEF);
        release_rst();
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        check("ld_exec_retire", 32'(retire), 0);
        check("ld_exec_req", 32'(mem_req), 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check("ld_wait_req", 32'(mem_req), 1);
            check("ld_wait_addr", 32'(mem_addr), 32'h050);
            check("ld_wait_we", 32'(mem_we), 0);
            check("ld_wait_retire", 32'(retire), 0);
        end
        @(negedge clk);
        mem_ready = 1'b1;
        #1;
        check("ld_ready_retire", 32'(retire), 1);
        check("ld_ready_addr", 32'(mem_addr), 32'h050);
        wait_halt(cyc);
        check("ld_st_cycles", 32'(cyc), 6);
        end_run(2, 3);

        // Illegal opcode: sticky flag, executes as NOP, then HALT holds
        do_reset();
        mem[0] = 16'hC407;
        mem[1] = 16'h4455;
        mem[2] = 16'h1460;
        expect_store(10'h060, 16'h0007);
        release_rst();
        repeat (3) @(negedge clk);
        #1;
        check("illegal_pre", 32'(illegal), 0);
        check("illegal_retire", 32'(retire), 1);
        @(negedge clk);
        #1;
        check("illegal_set", 32'(illegal), 1);
        wait_halt(cyc);
        end_run(3, 4);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            check("halt_hold_req", 32'(mem_req), 0);
        end
        check("halt_hold", 32'(halted), 1);
        check("illegal_sticky", 32'(illegal), 1);

        // Reset in the middle of a LOAD wait
        do_reset();
        mem[0]       = 16'h0450;
        mem[10'h050] = 16'h1234;
        release_rst();
        @(negedge clk);
        mem_ready = 1'b0;
        @(negedge clk);
        #1;
        check("rst_wait_req", 32'(mem_req), 1);
        @(negedge clk);
        rst       = 1'b1;
        mem_ready = 1'b1;
        #1;
        check("rst_mid_req", 32'(mem_req), 0);
        check("rst_mid_retire", 32'(retire), 0);
        mem[0] = 16'h1453;
        mem[1] = 16'h7000;
        exp_q.delete();
        n_st_exp = 0;
        expect_store(10'h053, 16'h0000);
        @(negedge clk);
        #1;
        check("rst_mid_pc", 32'(pc), 0);
        release_rst();
        wait_halt(cyc);
        end_run(1, 2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
